// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, priority flush,
// bubble payload and saturating stall counter. Define PIPE_STAGE_REG_SKID_EN for a 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] dat_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] dat_o,
  output logic [1:0]       occupancy_o,
  input  logic             stall_cnt_clr_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // State encoding doubles as the held-beat count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             in_xfer_s;
  logic             out_xfer_s;

  assign valid_o     = (state_r != ST_EMPTY);
  assign dat_o       = main_r;
  assign occupancy_o = state_r;
  assign stall_cnt_o = stall_cnt_r;
  assign in_xfer_s   = valid_i & ready_o;
  assign out_xfer_s  = valid_o & ready_i;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             ready_r;

  assign ready_o = ready_r;

  // Next-state and payload steering for main + skid entries.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (flush_i) begin
      state_s = ST_EMPTY;
      main_s  = NOP_VALUE;
      skid_s  = NOP_VALUE;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_s = ST_FULL;
            main_s  = dat_i;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (in_xfer_s && !ready_i) begin
            state_s = ST_SKID;
            skid_s  = dat_i;
          end else if (in_xfer_s) begin
            state_s = ST_FULL;
            main_s  = dat_i;
          end else if (out_xfer_s) begin
            state_s = ST_EMPTY;
            main_s  = NOP_VALUE;
          end else begin
            state_s = ST_FULL;
          end
        end
        ST_SKID: begin
          if (ready_i) begin
            state_s = ST_FULL;
            main_s  = skid_r;
            skid_s  = NOP_VALUE;
          end else begin
            state_s = ST_SKID;
          end
        end
        default: begin
          state_s = ST_EMPTY;
          main_s  = NOP_VALUE;
          skid_s  = NOP_VALUE;
        end
      endcase
    end
  end

  // Skid entry and registered ready, so ready_i never reaches ready_o combinationally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_r  <= NOP_VALUE;
      ready_r <= 1'b1;
    end else begin
      skid_r  <= skid_s;
      ready_r <= (state_s != ST_SKID);
    end
  end
`else
  assign ready_o = ~valid_o | ready_i;

  // Next-state and payload steering for the single entry.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    if (flush_i) begin
      state_s = ST_EMPTY;
      main_s  = NOP_VALUE;
    end else if (in_xfer_s) begin
      state_s = ST_FULL;
      main_s  = dat_i;
    end else if (out_xfer_s) begin
      state_s = ST_EMPTY;
      main_s  = NOP_VALUE;
    end else begin
      state_s = state_r;
      main_s  = main_r;
    end
  end
`endif

  // Main entry and state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_EMPTY;
      main_r  <= NOP_VALUE;
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
    end
  end

  // Saturating stall counter; clear wins over a coincident stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_cnt_clr_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (valid_o && !ready_i && !flush_i && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule
